// File: rtl/serial_sub_engine_if.sv
// Operand stream and result bundle for the bit-serial subtractor.
// The master side feeds operand bits. The slave side is the engine, which returns the results.
interface serial_sub_engine_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             BIT_VALID;
  logic             A;
  logic             B;
  logic             D;
  logic [WIDTH-1:0] DIFF;
  logic             BO;
  logic             DONE;
  logic             BUSY;

  modport master (
    output START, BIT_VALID, A, B,
    input  D, DIFF, BO, DONE, BUSY
  );

  modport slave (
    input  START, BIT_VALID, A, B,
    output D, DIFF, BO, DONE, BUSY
  );
endinterface

// File: rtl/serial_sub_engine.sv
// Bit-serial subtractor. DIFF = A_word - B_word, with operands streamed LSB first.
// The borrow is held in a flop between beats.
// After WIDTH accepted beats the engine loads the parallel word and the final borrow.
// It also pulses DONE for one cycle at that point.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no frame in progress; waiting for START
// RUN   | frame in progress; each BIT_VALID beat consumes one bit pair
module serial_sub_engine #(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  serial_sub_engine_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIDTH - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic             state;
  logic             borrow;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             d_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bo_reg;
  logic             done_reg;

  logic             d_next;
  logic             borrow_next;
  logic [WIDTH-1:0] shift_next;

  // Supply pins are carried for netlist compatibility only
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Full-subtractor cell for the current bit pair
  always_comb begin
    d_next      = bus.A ^ bus.B ^ borrow;
    borrow_next = (~bus.A & bus.B) | (~(bus.A ^ bus.B) & borrow);
    shift_next  = {d_next, shift_reg[WIDTH-1:1]};
  end

  // Frame sequencing, beat accumulation and result capture
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= ST_IDLE;
      borrow    <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      d_reg     <= 1'b0;
      diff_reg  <= '0;
      bo_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.START) begin
        // START wins over BIT_VALID and also aborts a running frame
        state     <= ST_RUN;
        borrow    <= 1'b0;
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (state == ST_RUN && bus.BIT_VALID) begin
        d_reg     <= d_next;
        borrow    <= borrow_next;
        shift_reg <= shift_next;
        if (bit_cnt == LAST_BEAT) begin
          diff_reg <= shift_next;
          bo_reg   <= borrow_next;
          done_reg <= 1'b1;
          state    <= ST_IDLE;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.D    = d_reg;
  assign bus.DIFF = diff_reg;
  assign bus.BO   = bo_reg;
  assign bus.DONE = done_reg;
  assign bus.BUSY = (state == ST_RUN);

endmodule

// File: tb/tb_serial_sub_engine.sv
// Directed and randomized frames for the bit-serial subtractor.
// Expected results come from plain word arithmetic.
module tb_serial_sub_engine;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RN;
  wire  vdd_net;
  wire  vss_net;
  assign vdd_net = 1'b1;
  assign vss_net = 1'b0;

  serial_sub_engine_if #(.WIDTH(W)) bus ();

  serial_sub_engine #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RN  (RN),
    .VDD (vdd_net),
    .VSS (vss_net),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] prev_diff;
  logic         prev_bo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs a frame starting with a START cycle.
  // With chain set, the START is driven in the current cycle. That is used for back-to-back frames in the DONE cycle.
  task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b, input int gap_max,
                       input bit bv_start, input bit chain);
    logic [W-1:0] exp_d;
    logic         exp_bo;
    int           gap;
    exp_d  = a - b;
    exp_bo = (a < b);
    if (!chain) @(negedge CLK);
    bus.START     = 1'b1;
    bus.BIT_VALID = bv_start;
    bus.A         = 1'($urandom);
    bus.B         = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
        @(negedge CLK);
        check("busy_gap", bus.BUSY, 1);
        bus.START     = 1'b0;
        bus.BIT_VALID = 1'b0;
        bus.A         = 1'($urandom);
        bus.B         = 1'($urandom);
      end
      @(negedge CLK);
      check("busy_run", bus.BUSY, 1);
      check("done_low", bus.DONE, 0);
      check("diff_held", bus.DIFF, prev_diff);
      check("bo_held", bus.BO, prev_bo);
      if (i > 0) check("d_bit", bus.D, exp_d[i-1]);
      bus.START     = 1'b0;
      bus.BIT_VALID = 1'b1;
      bus.A         = a[i];
      bus.B         = b[i];
    end
    @(negedge CLK);
    check("done_pulse", bus.DONE, 1);
    check("busy_done", bus.BUSY, 0);
    check("diff", bus.DIFF, exp_d);
    check("bo", bus.BO, exp_bo);
    check("d_msb", bus.D, exp_d[W-1]);
    bus.BIT_VALID = 1'b0;
    bus.A         = 1'b0;
    bus.B         = 1'b0;
    prev_diff     = exp_d;
    prev_bo       = exp_bo;
  endtask

  // Starts a frame and feeds only n beats of it.
  task automatic partial(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    @(negedge CLK);
    bus.START     = 1'b1;
    bus.BIT_VALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("busy_part", bus.BUSY, 1);
      bus.START     = 1'b0;
      bus.BIT_VALID = 1'b1;
      bus.A         = a[i];
      bus.B         = b[i];
    end
    @(negedge CLK);
    check("diff_part_held", bus.DIFF, prev_diff);
    check("done_part", bus.DONE, 0);
    bus.BIT_VALID = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    RN            = 1'b0;
    bus.START     = 1'b0;
    bus.BIT_VALID = 1'b0;
    bus.A         = 1'b0;
    bus.B         = 1'b0;
    prev_diff     = '0;
    prev_bo       = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_d", bus.D, 0);
    check("rst_diff", bus.DIFF, 0);
    check("rst_bo", bus.BO, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_busy", bus.BUSY, 0);
    RN = 1'b1;

    frame(8'h5A, 8'h3C, 0, 1'b0, 1'b0);
    frame(8'h10, 8'h20, 0, 1'b0, 1'b0);
    frame(8'h00, 8'h01, 0, 1'b0, 1'b0);
    frame(8'hFF, 8'hFF, 0, 1'b0, 1'b0);

    // BIT_VALID in IDLE must not consume bits
    repeat (3) begin
      @(negedge CLK);
      check("idle_busy", bus.BUSY, 0);
      bus.BIT_VALID = 1'b1;
      bus.A         = 1'b1;
      bus.B         = 1'b0;
    end
    frame(8'hA5, 8'h5A, 3, 1'b1, 1'b0);

    // Abort mid-frame with a restart
    partial(8'h33, 8'h11, 4);
    frame(8'h80, 8'h01, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    partial(8'h77, 8'h12, 5);
    #2 RN = 1'b0;
    #1;
    check("arst_d", bus.D, 0);
    check("arst_diff", bus.DIFF, 0);
    check("arst_bo", bus.BO, 0);
    check("arst_done", bus.DONE, 0);
    check("arst_busy", bus.BUSY, 0);
    prev_diff = '0;
    prev_bo   = 1'b0;
    @(negedge CLK);
    RN = 1'b1;
    frame(8'h02, 8'h03, 0, 1'b0, 1'b0);

    // Back-to-back frames with START in the DONE cycle
    frame(8'h9C, 8'h47, 1, 1'b0, 1'b0);
    frame(8'h21, 8'h43, 1, 1'b0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      frame(ra, rb, 3, 1'($urandom), 1'($urandom));
    end

    @(negedge CLK);
    check("final_done", bus.DONE, 0);
    check("final_busy", bus.BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub_engine.md
Name: serial_sub_engine

Overview:
Bit-serial subtractor: the inverse-direction companion to the half-adder cells. It computes DIFF = A_word - B_word, with operands streamed LSB-first one bit pair per accepted beat, and keeps the borrow in a flop between beats. After WIDTH beats it presents the parallel difference word and the final borrow with a one-cycle DONE strobe. It sits between serial operand sources and parallel consumers in low-area arithmetic datapaths.

Parameters:
WIDTH, 8, operand/result word width in bits; legal range 2..32.

Ports:
CLK  input  1  rising-edge clock.
RN  input  1  asynchronous active-low reset.
VDD  inout  1  power.
VSS  inout  1  ground.
START  input  1  frame start; 1-cycle pulse.
BIT_VALID  input  1  A/B carry a valid bit pair this cycle.
A  input  1  minuend bit, LSB first.
B  input  1  subtrahend bit, LSB first.
D  output  1  registered difference bit of the last accepted beat.
DIFF  output  WIDTH  completed difference word; holds until next completion.
BO  output  1  final borrow-out of the last completed frame (1 = A_word < B_word).
DONE  output  1  1-cycle pulse when DIFF/BO update.
BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (RN=0, async): state=IDLE; borrow, bit counter and internal shift register cleared; D=0, DIFF=0, BO=0, DONE=0, BUSY=0. Reset mid-frame discards the partial frame.
- States: IDLE, RUN. BUSY=1 exactly in RUN.
- IDLE: START=1 -> clear borrow, counter=0, shift register=0, go to RUN. BIT_VALID is ignored in IDLE, including in the START cycle (START has priority; no bit consumed).
- RUN, per edge with BIT_VALID=1: d = A^B^borrow; borrow_next = (~A & B) | (~(A^B) & borrow); D<=d; shift register shifts right with d entering at bit WIDTH-1; counter++.
- RUN, BIT_VALID=0: no state change; D holds. Gaps of any length are legal.
- Completion: on the edge accepting beat WIDTH-1 (counter==WIDTH-1), DIFF<=final shifted word, BO<=borrow_next, DONE<=1 for exactly the following cycle, state<=IDLE. Latency: DONE is high in the cycle immediately after the last bit is sampled.
- START in RUN: aborts the current frame and restarts (borrow, counter and shift register cleared, BIT_VALID that cycle ignored). DIFF/BO are unchanged and no DONE is issued.
- START in the cycle DONE is high: legal; begins a new frame (state is already IDLE).
- DIFF and BO change only at completion. DONE is never asserted for an aborted frame.
- Arithmetic is modulo 2^WIDTH; BO equals the borrow out of the MSB.
- Counter width: clog2(WIDTH). No wrap is possible because the counter returns to IDLE at WIDTH-1.

Test Plan:
- Reset, then frame 0x5A - 0x3C with continuous BIT_VALID -> DONE 1 cycle after 8th bit; DIFF=0x1E, BO=0; BUSY low same cycle as DONE.
- Frames 0x10-0x20 -> DIFF=0xF0, BO=1; 0x00-0x01 -> DIFF=0xFF, BO=1; 0xFF-0xFF -> DIFF=0x00, BO=0.
- 0xA5-0x5A with random 0-3 cycle BIT_VALID gaps, plus BIT_VALID pulses in IDLE and in the START cycle -> DIFF=0x4B, BO=0; ignored beats do not shift.
- Start 0x33-0x11, issue START after 4 bits, then send 0x80-0x01 -> no DONE for the first frame; DIFF=0x7F, BO=0; previous DIFF held until completion.
- Assert RN low after 5 bits of a frame -> all outputs 0 immediately (async); a subsequent full frame 0x02-0x03 -> DIFF=0xFF, BO=1.
- Back-to-back frames with START in the DONE cycle -> second frame result is correct and there are no lost or extra beats.
